// File: rtl/controller_cripto.sv
// Iterative AES-128 encryption core: one round per clock, round key derived
// on the fly from the previous one, so no key schedule is stored.
//
// state | meaning
// IDLE  | waiting for start; palavra/chave sampled on the accept edge
// ROUND | rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey
// FINAL | round 10 without MixColumns; result written to cifra
// DONE  | done pulse for one cycle, then back to IDLE
module controller_cripto (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] chave,
    input  logic [127:0] palavra,
    output logic [127:0] cifra,
    output logic         done,
    output logic         busy,
    output logic [2:0]   estado
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ROUND = 3'd1,
        FINAL = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state;
    logic [127:0] st;
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic [127:0] rk_n;
    logic [127:0] sr;
    logic [127:0] round_out;
    logic [127:0] final_out;

    // Single S-box lookup used by both the data path and SubWord.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return r;
    endfunction

    // Byte k = r + 4c sits at bits [127-8k -: 8]; row r rotates left by r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        b0 = xtime(a0);
        b1 = xtime(a1);
        b2 = xtime(a2);
        b3 = xtime(a3);
        return {b0 ^ a1 ^ b1 ^ a2 ^ a3,
                a0 ^ b1 ^ a2 ^ b2 ^ a3,
                a0 ^ a1 ^ b2 ^ a3 ^ b3,
                a0 ^ b0 ^ a1 ^ a2 ^ b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        for (int col = 0; col < 4; col++) begin
            r[127-32*col -: 32] = mix_col(s[127-32*col -: 32]);
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // rnd is 10 while in FINAL, so the same expansion yields the last round key.
    assign rk_n      = key_expand(rk, rcon(rnd));
    assign sr        = shift_rows(sub_bytes(st));
    assign round_out = mix_columns(sr) ^ rk_n;
    assign final_out = sr ^ rk_n;
    assign estado    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rnd   <= '0;
            cifra <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        st    <= palavra ^ chave;
                        rk    <= chave;
                        rnd   <= 4'd1;
                        busy  <= 1'b1;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    rk  <= rk_n;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd9) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    cifra <= final_out;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_cripto.sv
// Bench for controller_cripto: known-answer table, hand-written corner
// sequences, and random operations against a byte-level AES-128 model.
module tb_controller_cripto;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] chave;
    logic [127:0] palavra;
    logic [127:0] cifra;
    logic         done;
    logic         busy;
    logic [2:0]   estado;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] sbox_t [256];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vt [3];

    controller_cripto dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .chave   (chave),
        .palavra (palavra),
        .cifra   (cifra),
        .done    (done),
        .busy    (busy),
        .estado  (estado)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] r1);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coeffs [4];
        logic [7:0]   acc;
        coeffs[0] = 8'h02;
        coeffs[1] = 8'h03;
        coeffs[2] = 8'h01;
        coeffs[3] = 8'h01;
        r1 = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coeffs[(k - row + 4) % 4], s[k + 4*c]);
                        t[row + 4*c] = acc;
                    end
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            if (r == 1) for (int i = 0; i < 16; i++) r1[127-8*i -: 8] = s[i];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    // One operation from IDLE; lat is the edge (accept = 0) after which done is seen.
    task automatic run_op(input logic [127:0] pt, input logic [127:0] key, input bit scramble,
                          output logic [127:0] ct, output int lat);
        @(negedge clk);
        start   = 1'b1;
        palavra = pt;
        chave   = key;
        @(negedge clk);
        start = 1'b0;
        chk("accept_estado", 128'(estado), 128'd1);
        chk("accept_busy", 128'(busy), 128'd1);
        lat = -1;
        for (int e = 1; e <= 30 && lat < 0; e++) begin
            if (scramble) begin
                palavra = rand128();
                chave   = rand128();
                start   = (e <= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            if (done) lat = e;
        end
        start = 1'b0;
        ct = cifra;
        @(negedge clk);
        chk("done_width", 128'(done), 128'd0);
        chk("idle_after_done", 128'(estado), 128'd0);
        chk("busy_after_done", 128'(busy), 128'd0);
        chk("cifra_hold_idle", cifra, ct);
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        logic [127:0] ct, exp_ct, exp_r1;
        int           lat, cnt, nd;
        int           dcyc [2];
        logic [127:0] dct  [2];

        build_sbox();
        vt[0] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                  ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vt[1] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vt[2] = '{pt: 128'h0, key: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // reset dominates start
        rst     = 1'b1;
        start   = 1'b1;
        palavra = vt[0].pt;
        chave   = vt[0].key;
        repeat (3) @(negedge clk);
        chk("reset_estado", 128'(estado), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_cifra", cifra, 128'd0);
        rst   = 1'b0;
        start = 1'b0;

        // known-answer vectors
        for (int i = 0; i < 3; i++) begin
            run_op(vt[i].pt, vt[i].key, 1'b0, ct, lat);
            chk($sformatf("kat%0d_cifra", i), ct, vt[i].ct);
            chk($sformatf("kat%0d_latency", i), 128'(lat), 128'd10);
        end

        // intermediate state of the FIPS-197 appendix B example
        @(negedge clk);
        start   = 1'b1;
        palavra = vt[1].pt;
        chave   = vt[1].key;
        @(negedge clk);
        start = 1'b0;
        chk("v2_st_edge0", dut.st, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        @(negedge clk);
        chk("v2_st_edge1", dut.st, 128'ha49c7ff2689f352b6b5bea43026a5049);
        lat = -1;
        for (int e = 2; e <= 30 && lat < 0; e++) begin
            @(negedge clk);
            if (done) lat = e;
        end
        chk("v2_seq_latency", 128'(lat), 128'd10);
        chk("v2_seq_cifra", cifra, vt[1].ct);
        @(negedge clk);

        // inputs and start wiggled while busy
        run_op(vt[2].pt, vt[2].key, 1'b1, ct, lat);
        chk("stable_cifra", ct, vt[2].ct);
        chk("stable_latency", 128'(lat), 128'd10);
        count_dones(15, cnt);
        chk("stable_no_extra_done", 128'(cnt), 128'd0);

        // reset asserted at edge 5 of vector 1
        @(negedge clk);
        start   = 1'b1;
        palavra = vt[0].pt;
        chave   = vt[0].key;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_estado", 128'(estado), 128'd0);
        chk("abort_cifra", cifra, 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        count_dones(20, cnt);
        chk("abort_no_done", 128'(cnt), 128'd0);
        run_op(vt[0].pt, vt[0].key, 1'b0, ct, lat);
        chk("after_abort_cifra", ct, vt[0].ct);

        // start held high: vector 1 then vector 2
        @(negedge clk);
        start   = 1'b1;
        palavra = vt[0].pt;
        chave   = vt[0].key;
        @(negedge clk);
        palavra = vt[1].pt;
        chave   = vt[1].key;
        nd = 0;
        for (int i = 0; i < 40 && nd < 2; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc[nd] = cyc;
                dct[nd]  = cifra;
                nd++;
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 128'(nd), 128'd2);
        if (nd == 2) begin
            chk("b2b_gap", 128'(dcyc[1] - dcyc[0]), 128'd12);
            chk("b2b_cifra0", dct[0], vt[0].ct);
            chk("b2b_cifra1", dct[1], vt[1].ct);
        end
        count_dones(14, cnt);
        chk("b2b_no_third", 128'(cnt), 128'd0);

        // random operations against the model
        for (int i = 0; i < 10; i++) begin
            logic [127:0] pt, key;
            pt  = rand128();
            key = (i == 0) ? 128'h0 : rand128();
            aes_ref(pt, key, exp_ct, exp_r1);
            run_op(pt, key, i[0], ct, lat);
            chk($sformatf("rand%0d_cifra", i), ct, exp_ct);
            chk($sformatf("rand%0d_latency", i), 128'(lat), 128'd10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller_cripto.md
CONTROLLER_CRIPTO -- requirements
Module: controller_cripto

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high. Ports: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 start  input  1  request pulse; sampled only in IDLE.
REQ-003 chave  input  128  cipher key, FIPS-197 byte order (byte 0 = bits [127:120], column-major state).
REQ-004 palavra  input  128  plaintext, same byte order as chave.
REQ-005 cifra  output  128  ciphertext register.
REQ-006 done  output  1  high for exactly one cycle when cifra is updated.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 estado  output  3  FSM state code: 0=IDLE, 1=ROUND, 2=FINAL, 3=DONE; codes 4-7 unused.

Function
REQ-009 SHALL implement AES-128 encryption iteratively, one round per clock, with on-the-fly key expansion; no stored key schedule.
REQ-010 Internal registers: st (128-bit state), rk (128-bit round key), rnd (4-bit round counter 0..10).
REQ-011 IDLE with start=1 (accept edge): st <= palavra ^ chave; rk <= chave; rnd <= 1; go to ROUND.
REQ-012 palavra and chave SHALL be sampled only on the accept edge; later changes have no effect on the current operation.
REQ-013 ROUND, each edge: rk_n = KeyExpand(rk, Rcon[rnd]); st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_n; rk <= rk_n; rnd <= rnd+1.
REQ-014 ROUND -> FINAL on the edge that completes round 9; otherwise stay in ROUND.
REQ-015 FINAL, one edge: cifra <= ShiftRows(SubBytes(st)) ^ KeyExpand(rk, Rcon[10]); MixColumns is omitted; go to DONE.
REQ-016 DONE: done=1 for this single cycle; next edge goes to IDLE unconditionally.
REQ-017 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex), XORed into the most-significant byte of the RotWord/SubWord result.
REQ-018 Latency: with the accept edge counted as edge 0, cifra is valid and done=1 after edge 10; the next accept is possible at edge 12 or later.
REQ-019 start SHALL be ignored in ROUND, FINAL and DONE; no queuing.
REQ-020 start held high continuously SHALL start a new operation on each IDLE visit: one operation every 12 cycles.
REQ-021 cifra SHALL hold its value from FINAL until the next FINAL or reset, and SHALL NOT change in IDLE, ROUND or DONE.
REQ-022 done SHALL be registered (high iff estado==DONE); busy SHALL be high iff estado!=IDLE.
REQ-023 Unused estado codes 4-7 SHALL go to IDLE on the next edge.
REQ-024 SubBytes SHALL use the FIPS-197 forward S-box; the same S-box function SHALL be shared by the datapath and the key-expansion SubWord.

Reset
REQ-025 rst=1 at a clock edge: estado=IDLE, st=0, rk=0, rnd=0, cifra=0, done=0, busy=0.
REQ-026 rst SHALL dominate start on the same edge.
REQ-027 rst mid-operation SHALL abort the operation: no done pulse, cifra=0.

Verification
REQ-028 Vector 1: palavra=00112233445566778899aabbccddeeff, chave=000102030405060708090a0b0c0d0e0f -> cifra=69c4e0d86a7b0430d8cdb78070b4c55a, with done 10 cycles after the accept edge.
REQ-029 Vector 2: palavra=3243f6a8885a308d313198a2e0370734, chave=2b7e151628aed2a6abf7158809cf4f3c -> st=193de3bea0f4e22b9ac68d2ae9f84808 after edge 0; st=a49c7ff2689f352b6b5bea43026a5049 after edge 1; cifra=3925841d02dc09fbdc118597196a0b32.
REQ-030 Vector 3: all-zero palavra and chave -> cifra=66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-031 Input stability: start pulse, then palavra/chave changed during ROUND -> result still equals the vector for the sampled inputs; extra start pulses while busy=1 produce no second done.
REQ-032 Reset abort: rst asserted at edge 5 of Vector 1 -> estado=0, cifra=0, no done pulse; a fresh start afterwards still yields 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-033 Back-to-back: start held high across Vector 1 then Vector 2 -> done pulses exactly 12 cycles apart, each with the correct cifra.
